// File: rtl/diff_core_pkg.sv
// Shared types for the diff_core layer sequencing path: the layer descriptor
// record and the job scheduler state encoding.
package diff_core_pkg;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] c;
    logic       kernal_mode;
    logic       bit_mode;
    logic       last;
  } layer_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RUN,
    NEXT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/layer_desc_fifo.sv
// Synchronous descriptor FIFO with flush; a push is accepted while full
// when a pop happens in the same cycle.
module layer_desc_fifo
  import diff_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  layer_desc_t wr_data,
  output layer_desc_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  layer_desc_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/layer_job_sched.sv
// Issues buffered layer descriptors one at a time to the guard-gen controller.
// Define LAYER_SCHED_PERF_EN to add the per-job RUN cycle counter outputs.
module layer_job_sched
  import diff_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            desc_valid,
  output logic            desc_ready,
  input  logic [7:0]      desc_w,
  input  logic [7:0]      desc_h,
  input  logic [7:0]      desc_c,
  input  logic            desc_kernal_mode,
  input  logic            desc_bit_mode,
  input  logic            desc_last,
  output logic            ctrl_valid,
  input  logic            ctrl_ready,
  input  logic            ctrl_finish,
  output logic [7:0]      w_num,
  output logic [7:0]      h_num,
  output logic [7:0]      c_num,
  output logic            kernal_mode,
  output logic            bit_mode,
  output logic [ID_W-1:0] job_id,
  output logic            busy,
  output logic            done
`ifdef LAYER_SCHED_PERF_EN
  ,
  output logic [31:0]     job_cycles,
  output logic            job_cycles_vld
`endif
);

  sched_state_e    state_q, state_d;
  logic [ID_W-1:0] job_id_q, job_id_d;
  logic            seen_busy_q, seen_busy_d;
  layer_desc_t     in_desc, head;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign in_desc    = {desc_w, desc_h, desc_c, desc_kernal_mode, desc_bit_mode, desc_last};
  assign fifo_pop   = (state_q == NEXT);
  assign desc_ready = !fifo_full || fifo_pop;
  assign fifo_push  = desc_valid && desc_ready && !abort;
  assign job_id     = job_id_q;

  layer_desc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_desc),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      job_id_q    <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_id_q    <= job_id_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  // The controller strobes finish while idle and right after a load, so a
  // finish only counts once it has been seen busy (ready low) in this job.
  always_comb begin
    state_d     = state_q;
    job_id_d    = job_id_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      IDLE: begin
        if (start && !fifo_empty) begin
          state_d  = ISSUE;
          job_id_d = '0;
        end
      end
      ISSUE: begin
        if (!fifo_empty && ctrl_ready) begin
          state_d     = RUN;
          seen_busy_d = 1'b0;
        end
      end
      RUN: begin
        if (!ctrl_ready) seen_busy_d = 1'b1;
        if (ctrl_finish && seen_busy_q) state_d = NEXT;
      end
      NEXT: begin
        if (head.last) begin
          state_d = DONE;
        end else begin
          state_d  = ISSUE;
          job_id_d = job_id_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    ctrl_valid  = (state_q == ISSUE) && !fifo_empty;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    w_num       = '0;
    h_num       = '0;
    c_num       = '0;
    kernal_mode = 1'b0;
    bit_mode    = 1'b0;
    if (ctrl_valid) begin
      w_num       = head.w;
      h_num       = head.h;
      c_num       = head.c;
      kernal_mode = head.kernal_mode;
      bit_mode    = head.bit_mode;
    end
  end

`ifdef LAYER_SCHED_PERF_EN
  logic [31:0] job_cycles_q, job_cycles_d;

  always_comb begin
    job_cycles_d = job_cycles_q;
    if (state_q == ISSUE && state_d == RUN) begin
      job_cycles_d = '0;
    end else if (state_q == RUN && job_cycles_q != '1) begin
      job_cycles_d = job_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) job_cycles_q <= '0;
    else        job_cycles_q <= job_cycles_d;
  end

  assign job_cycles     = job_cycles_q;
  assign job_cycles_vld = (state_q == NEXT);
`endif

endmodule

// File: tb/tb_layer_job_sched.sv
// Self-checking bench for layer_job_sched: a behavioural controller and a
// descriptor queue model predict every offer, job id and done pulse.
module tb_layer_job_sched;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  typedef struct {
    bit [7:0] w;
    bit [7:0] h;
    bit [7:0] c;
    bit       km;
    bit       bm;
    bit       last;
  } desc_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            desc_valid = 1'b0;
  logic            desc_ready;
  logic [7:0]      desc_w = '0, desc_h = '0, desc_c = '0;
  logic            desc_kernal_mode = 1'b0, desc_bit_mode = 1'b0, desc_last = 1'b0;
  logic            ctrl_valid;
  logic            ctrl_ready = 1'b0;
  logic            ctrl_finish = 1'b0;
  logic [7:0]      w_num, h_num, c_num;
  logic            kernal_mode, bit_mode;
  logic [ID_W-1:0] job_id;
  logic            busy, done;
`ifdef LAYER_SCHED_PERF_EN
  logic [31:0]     job_cycles;
  logic            job_cycles_vld;
`endif

  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    exp_id = 0;
  desc_t exp_q[$];

  layer_job_sched #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_w           (desc_w),
    .desc_h           (desc_h),
    .desc_c           (desc_c),
    .desc_kernal_mode (desc_kernal_mode),
    .desc_bit_mode    (desc_bit_mode),
    .desc_last        (desc_last),
    .ctrl_valid       (ctrl_valid),
    .ctrl_ready       (ctrl_ready),
    .ctrl_finish      (ctrl_finish),
    .w_num            (w_num),
    .h_num            (h_num),
    .c_num            (c_num),
    .kernal_mode      (kernal_mode),
    .bit_mode         (bit_mode),
    .job_id           (job_id),
    .busy             (busy),
    .done             (done)
`ifdef LAYER_SCHED_PERF_EN
    ,
    .job_cycles       (job_cycles),
    .job_cycles_vld   (job_cycles_vld)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    desc_valid = 1'b0;
    ctrl_ready = 1'b0;
    ctrl_finish = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    exp_id = 0;
  endtask

  function automatic desc_t rand_desc(input bit last);
    desc_t d;
    d.w = 8'($urandom_range(0, 255));
    d.h = 8'($urandom_range(0, 255));
    d.c = 8'($urandom_range(0, 255));
    d.km = 1'($urandom_range(0, 1));
    d.bm = 1'($urandom_range(0, 1));
    d.last = last;
    return d;
  endfunction

  function automatic desc_t make_desc(input int w, input int h, input int c, input bit last);
    desc_t d;
    d = rand_desc(last);
    d.w = 8'(w);
    d.h = 8'(h);
    d.c = 8'(c);
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    desc_w = d.w;
    desc_h = d.h;
    desc_c = d.c;
    desc_kernal_mode = d.km;
    desc_bit_mode = d.bm;
    desc_last = d.last;
  endtask

  task automatic push_desc(input desc_t d);
    int n;
    n = 0;
    while (desc_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL push_wait: desc_ready=%b, expected 1 within 50 cycles", desc_ready);
      return;
    end
    drive_desc(d);
    desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Plays the controller for one job and returns at the cycle the scheduler should be in NEXT.
  task automatic serve_job(input int busy_len, input bit hold_finish, output bit was_last);
    desc_t e;
    int    n;
    int    dc0;
    bit    bad;
    was_last = 1'b0;
    ctrl_ready = 1'b0;
    ctrl_finish = hold_finish;
    n = 0;
    while (ctrl_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (ctrl_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL offer: ctrl_valid=%b queued=%0d, expected offer of a queued descriptor",
               ctrl_valid, exp_q.size());
      ctrl_finish = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    was_last = e.last;
    checks++;
    if ({w_num, h_num, c_num, kernal_mode, bit_mode} !== {e.w, e.h, e.c, e.km, e.bm}) begin
      errors++;
      $display("[TB] FAIL payload: got w=%0d h=%0d c=%0d km=%b bm=%b, expected w=%0d h=%0d c=%0d km=%b bm=%b",
               w_num, h_num, c_num, kernal_mode, bit_mode, e.w, e.h, e.c, e.km, e.bm);
    end
    checks++;
    if (job_id !== ID_W'(exp_id)) begin
      errors++;
      $display("[TB] FAIL job_id: got %0d, expected %0d", job_id, exp_id % (1 << ID_W));
    end
    dc0 = done_cnt;
    ctrl_ready = 1'b1;
    tick();
    ctrl_finish = 1'b1;
    checks++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept: ctrl_valid=%b busy=%b, expected 0 and 1", ctrl_valid, busy);
    end
    tick();
    ctrl_ready = 1'b0;
    ctrl_finish = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      tick();
      if (ctrl_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL early_next: job left RUN before a qualified finish (bad=%b), expected 0", bad);
    end
    ctrl_ready = 1'b1;
    ctrl_finish = 1'b1;
    tick();
    ctrl_ready = 1'b0;
    ctrl_finish = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || ctrl_valid !== 1'b0 || done_cnt != dc0) begin
      errors++;
      $display("[TB] FAIL next_state: busy=%b done=%b ctrl_valid=%b dones=%0d, expected 1 0 0 %0d",
               busy, done, ctrl_valid, done_cnt, dc0);
    end
`ifdef LAYER_SCHED_PERF_EN
    checks++;
    if (job_cycles_vld !== 1'b1 || job_cycles !== 32'(busy_len + 2)) begin
      errors++;
      $display("[TB] FAIL job_cycles: got %0d vld=%b, expected %0d vld=1",
               job_cycles, job_cycles_vld, busy_len + 2);
    end
`endif
    if (!e.last) exp_id = (exp_id + 1) % (1 << ID_W);
  endtask

  task automatic after_next(input bit was_last);
    tick();
    if (was_last) begin
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL done_pulse: done=%b, expected 1", done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL done_end: done=%b busy=%b, expected 0 0", done, busy);
      end
    end
  endtask

  task automatic serve_rand(input bit hold_finish);
    bit last;
    serve_job($urandom_range(1, 4), hold_finish, last);
    after_next(last);
  endtask

  task automatic test_reset();
    desc_t d;
    do_reset();
    checks++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || job_id !== '0 ||
        desc_ready !== 1'b1 || {w_num, h_num, c_num, kernal_mode, bit_mode} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b busy=%b done=%b id=%0d ready=%b w=%0d, expected 0 0 0 0 1 0",
               ctrl_valid, busy, done, job_id, desc_ready, w_num);
    end
    d = rand_desc(1'b1);
    push_desc(d);
    pulse_start();
    checks++;
    if (ctrl_valid !== 1'b1 || w_num !== d.w) begin
      errors++;
      $display("[TB] FAIL offer_before_reset: valid=%b w=%0d, expected 1 %0d", ctrl_valid, w_num, d.w);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1 || w_num !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b busy=%b ready=%b w=%0d, expected 0 0 1 0",
               ctrl_valid, busy, desc_ready, w_num);
    end
    do_reset();
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flush: busy=%b after start on flushed FIFO, expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int dc0;
    do_reset();
    dc0 = done_cnt;
    push_desc(make_desc(4, 2, 3, 1'b0));
    push_desc(make_desc(8, 8, 1, 1'b1));
    pulse_start();
    serve_rand(1'b0);
    serve_rand(1'b0);
    repeat (3) tick();
    checks++;
    if (done_cnt - dc0 != 1) begin
      errors++;
      $display("[TB] FAIL basic_done_count: got %0d, expected 1", done_cnt - dc0);
    end
  endtask

  task automatic test_early_finish();
    do_reset();
    ctrl_finish = 1'b1;
    push_desc(rand_desc(1'b1));
    tick();
    pulse_start();
    serve_rand(1'b1);
  endtask

  task automatic test_full();
    desc_t d5;
    bit    last;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_desc(rand_desc(1'b0));
    checks++;
    if (desc_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: desc_ready=%b, expected 0", desc_ready);
    end
    pulse_start();
    serve_job($urandom_range(1, 4), 1'b0, last);
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pop_ready: desc_ready=%b while popping full FIFO, expected 1", desc_ready);
    end
    d5 = rand_desc(1'b1);
    drive_desc(d5);
    desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    exp_q.push_back(d5);
    checks++;
    if (desc_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL still_full: desc_ready=%b after push+pop, expected 0", desc_ready);
    end
    for (int i = 0; i < DEPTH; i++) serve_rand(1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    push_desc(rand_desc(1'b0));
    pulse_start();
    serve_rand(1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall: ctrl_valid=%b busy=%b, expected 0 1", ctrl_valid, busy);
      end
      tick();
    end
    push_desc(rand_desc(1'b1));
    checks++;
    if (ctrl_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_resume: ctrl_valid=%b, expected 1", ctrl_valid);
    end
    serve_rand(1'b0);
  endtask

  task automatic test_abort();
    int dc0;
    int n;
    do_reset();
    dc0 = done_cnt;
    push_desc(rand_desc(1'b0));
    push_desc(rand_desc(1'b0));
    push_desc(rand_desc(1'b1));
    pulse_start();
    n = 0;
    while (ctrl_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ctrl_ready = 1'b1;
    tick();
    ctrl_ready = 1'b0;
    tick();
    abort = 1'b1;
    drive_desc(rand_desc(1'b1));
    desc_valid = 1'b1;
    tick();
    abort = 1'b0;
    desc_valid = 1'b0;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0 || ctrl_valid !== 1'b0 || desc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_state: busy=%b valid=%b ready=%b, expected 0 0 1", busy, ctrl_valid, desc_ready);
    end
    pulse_start();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != dc0) begin
      errors++;
      $display("[TB] FAIL abort_empty: busy=%b dones=%0d, expected 0 %0d", busy, done_cnt, dc0);
    end
    exp_id = 0;
    push_desc(rand_desc(1'b1));
    pulse_start();
    serve_rand(1'b0);
  endtask

  task automatic test_wrap();
    int pushed;
    int dc0;
    do_reset();
    dc0 = done_cnt;
    pushed = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push_desc((pushed == 5) ? make_desc(0, 0, 0, 1'b0) : rand_desc(1'b0));
      pushed++;
    end
    pulse_start();
    for (int j = 0; j < 18; j++) begin
      while (exp_q.size() < DEPTH && pushed < 18) begin
        push_desc((pushed == 5) ? make_desc(0, 0, 0, 1'b0) : rand_desc(pushed == 17));
        pushed++;
      end
      serve_rand(1'b0);
    end
    checks++;
    if (done_cnt - dc0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_done: dones=%0d busy=%b, expected 1 0", done_cnt - dc0, busy);
    end
  endtask

  initial begin
    $display("[TB] layer_job_sched bench start");
    test_reset();
    test_basic();
    test_early_finish();
    test_full();
    test_stall();
    test_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
